// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory port arbiter:
//   arb_state_t : arbiter FSM encoding (IDLE, D_BUS, I_BUS)
//   SEL_ALL     : all-ones byte-strobe pattern, sliced to the bus strobe width
//   TMR_W       : width of the bus wait counter
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_BUS = 2'd1,
      I_BUS = 2'd2
   } arb_state_t;

   localparam int                MAX_SW  = 64;
   localparam logic [MAX_SW-1:0] SEL_ALL = '1;

   localparam int TMR_W = 8;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Counts bus wait cycles of the transaction in flight and flags expiry.
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   i_clr    : return the count to zero (transaction finished); wins over i_en
//   i_en     : one more cycle spent waiting for bus_ack
//   o_expire : this waiting cycle is the TIMEOUT-th one; the transaction
//              must be abandoned at the coming edge
// -----------------------------------------------------------------------------
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   // The count reaches TIMEOUT at the edge that ends the TIMEOUT-th wait cycle,
   // so expiry is flagged while the count still reads TIMEOUT-1.
   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT - 1);

   logic [TMR_W-1:0] r_cnt;

   // NOTE: state is updated with <= so every flop samples the pre-edge values,
   // regardless of the order in which the simulator runs the blocks.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expire = i_en & (r_cnt == LAST);

endmodule : mem_arb_timer

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory bus between the fetch side and the MEM-stage data side of
// the pipelined core. One bus transaction at a time, data side first; returned
// words are latched and a single pipeline stall is held until every request
// pending in the current cycle has been satisfied.
//   clk, rst              : clock (rising edge), synchronous active-low reset
//   i_req/i_addr/i_rdata  : fetch request (level), pcF, latched instruction
//   d_req/d_we/d_sel      : data request (level), write enable, byte strobes
//   d_addr/d_wdata/d_rdata: data address, store data, latched load data
//   stall                 : combinational pipeline stall
//   bus_req..bus_wdata    : registered bus command, held until bus_ack
//   bus_rdata/bus_ack     : read data, valid with the one-cycle ack pulse
//   bus_err               : sticky flag, a transaction hit TIMEOUT wait cycles
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int AW      = 32,
   parameter  int DW      = 32,
   parameter  int TIMEOUT = 255,
   localparam int SW      = DW / 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [SW-1:0] d_sel,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          stall,
   output logic          bus_req,
   output logic          bus_we,
   output logic [SW-1:0] bus_sel,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata,
   input  logic          bus_ack,
   output logic          bus_err
);

   typedef struct packed {
      logic          we;
      logic [SW-1:0] sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } bus_cmd_t;

   localparam logic [SW-1:0] FETCH_SEL = SEL_ALL[SW-1:0];

   arb_state_t    r_state,   w_state_nxt;
   logic          r_i_done,  w_i_done_nxt;
   logic          r_d_done,  w_d_done_nxt;
   logic          r_bus_req, w_bus_req_nxt;
   bus_cmd_t      r_cmd,     w_cmd_nxt;
   logic [DW-1:0] r_i_rdata, w_i_rdata_nxt;
   logic [DW-1:0] r_d_rdata, w_d_rdata_nxt;
   logic          r_bus_err, w_bus_err_nxt;

   logic          w_i_pend;
   logic          w_d_pend;
   logic          w_busy;
   logic          w_stall;
   logic          w_tmr_en;
   logic          w_expire;
   logic          w_xfer_end;
   logic [DW-1:0] w_cap_data;
   bus_cmd_t      w_d_cmd;
   bus_cmd_t      w_i_cmd;

   // A request counts as pending only until its word has been captured; the
   // done flags keep a satisfied side from being re-issued while the other
   // side is still being served and the core is still holding both requests.
   assign w_i_pend = i_req & ~r_i_done;
   assign w_d_pend = d_req & ~r_d_done;
   assign w_busy   = (r_state != IDLE);
   assign w_stall  = w_i_pend | w_d_pend | w_busy;

   // An ack arriving on the expiry cycle wins: the timer is disabled by the ack,
   // so w_expire can only be set on a cycle without one.
   assign w_tmr_en   = w_busy & ~bus_ack;
   assign w_xfer_end = w_busy & (bus_ack | w_expire);
   assign w_cap_data = bus_ack ? bus_rdata : '0;

   assign w_d_cmd = {d_we, d_sel, d_addr, d_wdata};
   assign w_i_cmd = {1'b0, FETCH_SEL, i_addr, {DW{1'b0}}};

   mem_arb_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_xfer_end),
      .i_en     (w_tmr_en),
      .o_expire (w_expire)
   );

   // NOTE: every signal written here gets its hold value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_i_done_nxt  = r_i_done;
      w_d_done_nxt  = r_d_done;
      w_bus_req_nxt = r_bus_req;
      w_cmd_nxt     = r_cmd;
      w_i_rdata_nxt = r_i_rdata;
      w_d_rdata_nxt = r_d_rdata;
      w_bus_err_nxt = r_bus_err | w_expire;

      // Pipeline advances on this edge: both requests are fresh next cycle.
      if (!w_stall) begin
         w_i_done_nxt = 1'b0;
         w_d_done_nxt = 1'b0;
      end

      case (r_state)
         IDLE: begin
            if (w_d_pend) begin
               w_state_nxt   = D_BUS;
               w_cmd_nxt     = w_d_cmd;
               w_bus_req_nxt = 1'b1;
            end else if (w_i_pend) begin
               w_state_nxt   = I_BUS;
               w_cmd_nxt     = w_i_cmd;
               w_bus_req_nxt = 1'b1;
            end
         end

         D_BUS: begin
            if (w_xfer_end) begin
               w_d_done_nxt = 1'b1;
               if (!r_cmd.we) begin
                  w_d_rdata_nxt = w_cap_data;
               end
               // Chain straight into the fetch so the bus never idles between.
               if (w_i_pend) begin
                  w_state_nxt = I_BUS;
                  w_cmd_nxt   = w_i_cmd;
               end else begin
                  w_state_nxt   = IDLE;
                  w_bus_req_nxt = 1'b0;
               end
            end
         end

         I_BUS: begin
            if (w_xfer_end) begin
               w_i_done_nxt  = 1'b1;
               w_i_rdata_nxt = w_cap_data;
               if (w_d_pend) begin
                  w_state_nxt = D_BUS;
                  w_cmd_nxt   = w_d_cmd;
               end else begin
                  w_state_nxt   = IDLE;
                  w_bus_req_nxt = 1'b0;
               end
            end
         end

         default: begin
            w_state_nxt   = IDLE;
            w_bus_req_nxt = 1'b0;
         end
      endcase
   end

   // NOTE: only a handful of control/data flops here, so all of them are reset;
   // a reset mid-transaction simply drops the bus command.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_i_done  <= 1'b0;
         r_d_done  <= 1'b0;
         r_bus_req <= 1'b0;
         r_cmd     <= '0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_i_done  <= w_i_done_nxt;
         r_d_done  <= w_d_done_nxt;
         r_bus_req <= w_bus_req_nxt;
         r_cmd     <= w_cmd_nxt;
         r_i_rdata <= w_i_rdata_nxt;
         r_d_rdata <= w_d_rdata_nxt;
         r_bus_err <= w_bus_err_nxt;
      end
   end

   assign stall     = w_stall;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_cmd.we;
   assign bus_sel   = r_cmd.sel;
   assign bus_addr  = r_cmd.addr;
   assign bus_wdata = r_cmd.wdata;
   assign i_rdata   = r_i_rdata;
   assign d_rdata   = r_d_rdata;
   assign bus_err   = r_bus_err;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (TIMEOUT=4). The bench plays the core
// and the bus slave by hand; inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          d_req;
   logic          d_we;
   logic [SW-1:0] d_sel;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          stall;
   logic          bus_req;
   logic          bus_we;
   logic [SW-1:0] bus_sel;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic [DW-1:0] bus_rdata;
   logic          bus_ack;
   logic          bus_err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_port_arbiter #(
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_sel     (d_sel),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .stall     (stall),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_sel   (bus_sel),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      i_req     = 1'b0;
      i_addr    = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_sel     = '0;
      d_addr    = '0;
      d_wdata   = '0;
      bus_rdata = '0;
      bus_ack   = 1'b0;
   endtask

   // ---------------------------------------------------------------- reset
   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      tick();
      tick();
      n_tests++;
      if ({bus_req, bus_we, bus_sel} !== 6'b0) begin
         n_fail++; $display("FAIL reset_ctl got=%0h exp=0", {bus_req, bus_we, bus_sel});
      end
      n_tests++;
      if ({bus_addr, bus_wdata} !== 64'h0) begin
         n_fail++; $display("FAIL reset_bus got=%0h exp=0", {bus_addr, bus_wdata});
      end
      n_tests++;
      if ({i_rdata, d_rdata, bus_err} !== 65'h0) begin
         n_fail++; $display("FAIL reset_data got=%0h exp=0", {i_rdata, d_rdata, bus_err});
      end
      rst = 1'b1;
      tick();
      n_tests++;
      if ({stall, bus_req} !== 2'b00) begin
         n_fail++; $display("FAIL reset_idle got=%0b exp=00", {stall, bus_req});
      end
   endtask

   // ---------------------------------------------------------------- fetch
   task automatic test_fetch();
      int stall_cycles = 0;
      i_req  = 1'b1;
      i_addr = 32'hBFC0_0000;
      #1;
      stall_cycles += int'(stall);
      n_tests++;
      if (bus_req !== 1'b0) begin
         n_fail++; $display("FAIL fetch_req_early got=%0b exp=0", bus_req);
      end
      tick();
      stall_cycles += int'(stall);
      n_tests++;
      if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b0, 4'hF, 32'hBFC0_0000, 32'h0}) begin
         n_fail++; $display("FAIL fetch_cmd got=%0h exp=%0h",
                            {bus_req, bus_we, bus_sel, bus_addr, bus_wdata},
                            {1'b1, 1'b0, 4'hF, 32'hBFC0_0000, 32'h0});
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h3C01_0001;
      tick();
      bus_ack = 1'b0;
      #1;
      stall_cycles += int'(stall);
      n_tests++;
      if (stall_cycles !== 2) begin
         n_fail++; $display("FAIL fetch_stall_len got=%0d exp=2", stall_cycles);
      end
      n_tests++;
      if (i_rdata !== 32'h3C01_0001) begin
         n_fail++; $display("FAIL fetch_rdata got=%0h exp=3c010001", i_rdata);
      end
      n_tests++;
      if (bus_req !== 1'b0) begin
         n_fail++; $display("FAIL fetch_no_reissue got=%0b exp=0", bus_req);
      end
      // Pipeline advances with i_req still high: next fetch starts one edge later.
      i_addr = 32'hBFC0_0004;
      tick();
      n_tests++;
      if ({bus_req, stall} !== 2'b01) begin
         n_fail++; $display("FAIL fetch_advance got=%0b exp=01", {bus_req, stall});
      end
      tick();
      n_tests++;
      if ({bus_req, bus_addr} !== {1'b1, 32'hBFC0_0004}) begin
         n_fail++; $display("FAIL fetch2_cmd got=%0h exp=%0h", {bus_req, bus_addr}, {1'b1, 32'hBFC0_0004});
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h2421_0002;
      tick();
      bus_ack = 1'b0;
      #1;
      n_tests++;
      if ({i_rdata, stall} !== {32'h2421_0002, 1'b0}) begin
         n_fail++; $display("FAIL fetch2_rdata got=%0h exp=%0h", {i_rdata, stall}, {32'h2421_0002, 1'b0});
      end
      i_req = 1'b0;
      tick();
   endtask

   // ------------------------------------------------- simultaneous I + D
   task automatic test_back_to_back();
      int req_low = 0;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_sel  = 4'hF;
      d_addr = 32'h8000_0010;
      i_req  = 1'b1;
      i_addr = 32'hBFC0_0008;
      tick();
      n_tests++;
      if ({bus_req, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h8000_0010}) begin
         n_fail++; $display("FAIL b2b_d_cmd got=%0h exp=%0h", {bus_req, bus_we, bus_sel, bus_addr},
                            {1'b1, 1'b0, 4'hF, 32'h8000_0010});
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         if (bus_req !== 1'b1) req_low++;
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'hDEAD_BEEF;
      tick();
      bus_ack = 1'b0;
      #1;
      n_tests++;
      if ({bus_req, bus_sel, bus_addr, stall} !== {1'b1, 4'hF, 32'hBFC0_0008, 1'b1}) begin
         n_fail++; $display("FAIL b2b_i_cmd got=%0h exp=%0h", {bus_req, bus_sel, bus_addr, stall},
                            {1'b1, 4'hF, 32'hBFC0_0008, 1'b1});
      end
      n_tests++;
      if (d_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL b2b_d_rdata got=%0h exp=deadbeef", d_rdata);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         if ({bus_req, stall} !== 2'b11) req_low++;
      end
      n_tests++;
      if (req_low !== 0) begin
         n_fail++; $display("FAIL b2b_req_gap got=%0d exp=0", req_low);
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h1234_5678;
      tick();
      bus_ack = 1'b0;
      #1;
      n_tests++;
      if ({bus_req, stall, i_rdata, d_rdata} !== {1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF}) begin
         n_fail++; $display("FAIL b2b_done got=%0h exp=%0h", {bus_req, stall, i_rdata, d_rdata},
                            {1'b0, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF});
      end
      i_req = 1'b0;
      d_req = 1'b0;
      tick();
   endtask

   // ----------------------------------------------------------- byte store
   task automatic test_byte_store();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_sel   = 4'b0100;
      d_addr  = 32'h8000_0002;
      d_wdata = 32'h00AB_0000;
      tick();
      n_tests++;
      if ({bus_req, bus_we, bus_sel, bus_addr, bus_wdata} !== {1'b1, 1'b1, 4'b0100, 32'h8000_0002, 32'h00AB_0000}) begin
         n_fail++; $display("FAIL store_cmd got=%0h exp=%0h", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata},
                            {1'b1, 1'b1, 4'b0100, 32'h8000_0002, 32'h00AB_0000});
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'hFFFF_FFFF;
      tick();
      bus_ack = 1'b0;
      #1;
      n_tests++;
      if ({d_rdata, bus_err, stall, bus_req} !== {32'hDEAD_BEEF, 3'b000}) begin
         n_fail++; $display("FAIL store_done got=%0h exp=%0h", {d_rdata, bus_err, stall, bus_req},
                            {32'hDEAD_BEEF, 3'b000});
      end
      d_req = 1'b0;
      d_we  = 1'b0;
      tick();
   endtask

   // -------------------------------------------- ack on the expiry cycle
   task automatic test_ack_on_timeout();
      d_req  = 1'b1;
      d_sel  = 4'hF;
      d_addr = 32'h8000_0030;
      tick();
      for (int c = 0; c < 3; c++) tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'hCAFE_F00D;
      tick();
      bus_ack = 1'b0;
      #1;
      n_tests++;
      if ({bus_err, d_rdata, bus_req, stall} !== {1'b0, 32'hCAFE_F00D, 2'b00}) begin
         n_fail++; $display("FAIL ack_at_timeout got=%0h exp=%0h", {bus_err, d_rdata, bus_req, stall},
                            {1'b0, 32'hCAFE_F00D, 2'b00});
      end
      d_req = 1'b0;
      tick();
   endtask

   // ------------------------------------------------------------- timeout
   task automatic test_timeout();
      d_req  = 1'b1;
      d_sel  = 4'hF;
      d_addr = 32'h8000_0020;
      i_req  = 1'b1;
      i_addr = 32'hBFC0_0100;
      tick();
      for (int c = 0; c < 3; c++) tick();
      n_tests++;
      if ({bus_err, bus_req, bus_addr} !== {2'b01, 32'h8000_0020}) begin
         n_fail++; $display("FAIL timeout_early got=%0h exp=%0h", {bus_err, bus_req, bus_addr}, {2'b01, 32'h8000_0020});
      end
      tick();
      n_tests++;
      if ({bus_err, d_rdata} !== {1'b1, 32'h0}) begin
         n_fail++; $display("FAIL timeout_err got=%0h exp=%0h", {bus_err, d_rdata}, {1'b1, 32'h0});
      end
      n_tests++;
      if ({bus_req, bus_sel, bus_addr, stall} !== {1'b1, 4'hF, 32'hBFC0_0100, 1'b1}) begin
         n_fail++; $display("FAIL timeout_next got=%0h exp=%0h", {bus_req, bus_sel, bus_addr, stall},
                            {1'b1, 4'hF, 32'hBFC0_0100, 1'b1});
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h0BAD_C0DE;
      tick();
      bus_ack = 1'b0;
      #1;
      n_tests++;
      if ({i_rdata, bus_req, stall, bus_err} !== {32'h0BAD_C0DE, 3'b001}) begin
         n_fail++; $display("FAIL timeout_after got=%0h exp=%0h", {i_rdata, bus_req, stall, bus_err},
                            {32'h0BAD_C0DE, 3'b001});
      end
      d_req = 1'b0;
      i_req = 1'b0;
      tick();
      n_tests++;
      if (bus_err !== 1'b1) begin
         n_fail++; $display("FAIL timeout_sticky got=%0b exp=1", bus_err);
      end
   endtask

   // ------------------------------------------------ reset mid-transaction
   task automatic test_reset_mid();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      n_tests++;
      if ({bus_err, d_rdata, i_rdata} !== 65'h0) begin
         n_fail++; $display("FAIL rmid_clear got=%0h exp=0", {bus_err, d_rdata, i_rdata});
      end
      d_req  = 1'b1;
      d_sel  = 4'hF;
      d_addr = 32'h8000_0040;
      tick();
      n_tests++;
      if (bus_req !== 1'b1) begin
         n_fail++; $display("FAIL rmid_start got=%0b exp=1", bus_req);
      end
      rst   = 1'b0;
      d_req = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      n_tests++;
      if ({bus_req, stall} !== 2'b00) begin
         n_fail++; $display("FAIL rmid_abandon got=%0b exp=00", {bus_req, stall});
      end
      bus_ack   = 1'b1;
      bus_rdata = 32'h5555_5555;
      tick();
      bus_ack = 1'b0;
      n_tests++;
      if ({d_rdata, bus_req, stall} !== {32'h0, 2'b00}) begin
         n_fail++; $display("FAIL rmid_late_ack got=%0h exp=0", {d_rdata, bus_req, stall});
      end
      // A stuck done flag would hide this new request.
      d_req = 1'b1;
      #1;
      n_tests++;
      if (stall !== 1'b1) begin
         n_fail++; $display("FAIL rmid_flags got=%0b exp=1", stall);
      end
      tick();
      bus_ack   = 1'b1;
      bus_rdata = 32'h7777_0001;
      tick();
      bus_ack = 1'b0;
      #1;
      n_tests++;
      if ({d_rdata, stall} !== {32'h7777_0001, 1'b0}) begin
         n_fail++; $display("FAIL rmid_recover got=%0h exp=%0h", {d_rdata, stall}, {32'h7777_0001, 1'b0});
      end
      d_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_back_to_back();
      test_byte_store();
      test_ack_on_timeout();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule : tb_mem_port_arbiter
